uart_rx: RTL and testbench

Asynchronous serial receiver (8N1, LSB first), the receiving end of the team's UART link. It samples the serial input at mid-bit and reassembles bytes. Each completed byte is presented on a valid/ready output port toward the test harness or bridge logic, with framing-error and overrun reporting.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte output port of the UART receiver: valid/ready payload plus error strobes.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    // Receiver side drives the byte and strobes, consumer drives ready.
    modport master (
        output rx_data,
        output rx_data_valid,
        output rx_frame_err,
        output rx_overrun,
        input  rx_data_ready
    );

    modport slave (
        input  rx_data,
        input  rx_data_valid,
        input  rx_frame_err,
        input  rx_overrun,
        output rx_data_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, valid/ready byte output
// with one-cycle frame-error and overrun strobes.
module uart_rx #(
    parameter int unsigned CLK_FRE   = 50,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx_pin,
    uart_rx_if.master out_if
);

    localparam int unsigned CYCLE   = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int unsigned HALF    = CYCLE / 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned BIT_W   = 3;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_REC_BYTE,
        S_STOP
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cycle_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DATA_W-1:0]   shift_reg;
    logic                s0, s1, s2;
    logic [1:0]          settle;
    logic                deliver;
    logic                stop_bad;

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s0 <= rx_pin;
            s1 <= s0;
            s2 <= s1;
        end
    end

    // Edge detection is enabled only once s1 and s2 both hold real pin samples,
    // so a line that is already low at reset release cannot fake a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle <= 2'd0;
        end else if (settle != 2'd3) begin
            settle <= settle + 2'd1;
        end
    end

    // Receive FSM: start qualification, eight data bits, mid-stop-bit decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cycle_cnt <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            deliver   <= 1'b0;
            stop_bad  <= 1'b0;
        end else begin
            deliver  <= 1'b0;
            stop_bad <= 1'b0;
            case (state)
                S_IDLE: begin
                    cycle_cnt <= '0;
                    if (settle == 2'd3 && s2 && !s1) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cycle_cnt == CNT_W'(HALF - 1)) begin
                        cycle_cnt <= '0;
                        if (!s1) begin
                            state   <= S_REC_BYTE;
                            bit_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                S_REC_BYTE: begin
                    if (cycle_cnt == CNT_W'(CYCLE - 1)) begin
                        cycle_cnt          <= '0;
                        shift_reg[bit_cnt] <= s1;
                        if (bit_cnt == BIT_W'(7)) begin
                            state <= S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (cycle_cnt == CNT_W'(CYCLE - 1)) begin
                        cycle_cnt <= '0;
                        state     <= S_IDLE;
                        if (s1) begin
                            deliver <= 1'b1;
                        end else begin
                            stop_bad <= 1'b1;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cycle_cnt <= '0;
                end
            endcase
        end
    end

    // Output holding register: load when empty or drained on the same edge, else overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_if.rx_data       <= '0;
            out_if.rx_data_valid <= 1'b0;
            out_if.rx_frame_err  <= 1'b0;
            out_if.rx_overrun    <= 1'b0;
        end else begin
            out_if.rx_frame_err <= stop_bad;
            out_if.rx_overrun   <= 1'b0;
            if (deliver) begin
                if (!out_if.rx_data_valid || out_if.rx_data_ready) begin
                    out_if.rx_data       <= shift_reg;
                    out_if.rx_data_valid <= 1'b1;
                end else begin
                    out_if.rx_overrun <= 1'b1;
                end
            end else if (out_if.rx_data_valid && out_if.rx_data_ready) begin
                out_if.rx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at default parameters (434 clk per bit).
module tb_uart_rx;

    localparam int BIT = 434;

    logic clk;
    logic rst_n;
    logic rx_pin;

    uart_rx_if rx_if ();

    uart_rx dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_pin (rx_pin),
        .out_if (rx_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Observation counters, written only by the monitors below.
    int        cyc = 0;
    logic [7:0] acc_data [0:63];
    int        acc_n = 0;
    int        rise_n = 0;
    int        rise_cyc = 0;
    int        err_cyc = 0, err_rise = 0;
    int        ovr_cyc = 0, ovr_rise = 0;
    int        both_cnt = 0;
    logic      valid_prev = 1'b0, err_prev = 1'b0, ovr_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are taken with the values the DUT itself sees at the edge.
    always @(posedge clk) begin
        if (rst_n && rx_if.rx_data_valid && rx_if.rx_data_ready) begin
            if (acc_n < 64) acc_data[acc_n] = rx_if.rx_data;
            acc_n = acc_n + 1;
        end
    end

    // Strobe and valid-edge monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_if.rx_data_valid && !valid_prev) begin
            rise_n   = rise_n + 1;
            rise_cyc = cyc;
        end
        if (rx_if.rx_frame_err) err_cyc = err_cyc + 1;
        if (rx_if.rx_frame_err && !err_prev) err_rise = err_rise + 1;
        if (rx_if.rx_overrun) ovr_cyc = ovr_cyc + 1;
        if (rx_if.rx_overrun && !ovr_prev) ovr_rise = ovr_rise + 1;
        if (rx_if.rx_frame_err && rx_if.rx_overrun) both_cnt = both_cnt + 1;
        valid_prev = rx_if.rx_data_valid;
        err_prev   = rx_if.rx_frame_err;
        ovr_prev   = rx_if.rx_overrun;
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 rx_if.rx_data_ready = r;
    endtask

    // Drive one frame at negedges; t0 is the cycle count when the start bit begins.
    task automatic send_byte(input logic [7:0] b, input logic stop, output int t0);
        @(negedge clk);
        t0 = cyc;
        rx_pin = 1'b0;
        wait_neg(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            wait_neg(BIT);
        end
        rx_pin = stop;
        wait_neg(BIT);
        rx_pin = 1'b1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        rx_pin = 1'b1;
        rx_if.rx_data_ready = 1'b1;
        wait_neg(5);
        total++; if (rx_if.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", rx_if.rx_data); end
        total++; if (rx_if.rx_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", rx_if.rx_data_valid); end
        total++; if (rx_if.rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", rx_if.rx_frame_err); end
        total++; if (rx_if.rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", rx_if.rx_overrun); end
        rst_n = 1'b1;
        wait_neg(20);
    endtask

    task automatic test_single;
        int a0, e0, o0, t0, lat;
        a0 = acc_n; e0 = err_cyc; o0 = ovr_cyc;
        send_byte(8'hA5, 1'b1, t0);
        wait_neg(10);
        lat = rise_cyc - t0;
        total++; if (acc_n - a0 !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", acc_n - a0); end
        total++; if (acc_data[a0] !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", acc_data[a0]); end
        total++; if (lat < 4126 || lat > 4127) begin bad++; $display("FAIL single_latency got=%0d want=4126..4127", lat); end
        total++; if (err_cyc - e0 !== 0) begin bad++; $display("FAIL single_ferr got=%0d want=0", err_cyc - e0); end
        total++; if (ovr_cyc - o0 !== 0) begin bad++; $display("FAIL single_ovr got=%0d want=0", ovr_cyc - o0); end
    endtask

    task automatic test_back_to_back;
        int a0, e0, t0;
        a0 = acc_n; e0 = err_cyc;
        send_byte(8'h00, 1'b1, t0);
        send_byte(8'hFF, 1'b1, t0);
        wait_neg(10);
        total++; if (acc_n - a0 !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", acc_n - a0); end
        total++; if (acc_data[a0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h want=00", acc_data[a0]); end
        total++; if (acc_data[a0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h want=ff", acc_data[a0+1]); end
        total++; if (err_cyc - e0 !== 0) begin bad++; $display("FAIL b2b_ferr got=%0d want=0", err_cyc - e0); end
    endtask

    task automatic test_glitch;
        int a0, e0, r0, t0;
        a0 = acc_n; e0 = err_cyc; r0 = rise_n;
        @(negedge clk);
        rx_pin = 1'b0;
        wait_neg(100);
        rx_pin = 1'b1;
        wait_neg(11 * BIT);
        total++; if (rise_n - r0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", rise_n - r0); end
        total++; if (err_cyc - e0 !== 0) begin bad++; $display("FAIL glitch_ferr got=%0d want=0", err_cyc - e0); end
        send_byte(8'h96, 1'b1, t0);
        wait_neg(10);
        total++; if (acc_n - a0 !== 1) begin bad++; $display("FAIL glitch_recover_count got=%0d want=1", acc_n - a0); end
        total++; if (acc_data[a0] !== 8'h96) begin bad++; $display("FAIL glitch_recover_data got=%h want=96", acc_data[a0]); end
    endtask

    task automatic test_frame_err;
        int r0, e0, er0, o0, t0;
        r0 = rise_n; e0 = err_cyc; er0 = err_rise; o0 = ovr_cyc;
        send_byte(8'h3C, 1'b0, t0);
        wait_neg(2 * BIT);
        total++; if (err_rise - er0 !== 1) begin bad++; $display("FAIL ferr_pulses got=%0d want=1", err_rise - er0); end
        total++; if (err_cyc - e0 !== 1) begin bad++; $display("FAIL ferr_width got=%0d want=1", err_cyc - e0); end
        total++; if (rise_n - r0 !== 0) begin bad++; $display("FAIL ferr_valid got=%0d want=0", rise_n - r0); end
        total++; if (ovr_cyc - o0 !== 0) begin bad++; $display("FAIL ferr_ovr got=%0d want=0", ovr_cyc - o0); end
    endtask

    task automatic test_overrun;
        int a0, o0, or0, e0, t0;
        set_ready(1'b0);
        a0 = acc_n; o0 = ovr_cyc; or0 = ovr_rise; e0 = err_cyc;
        send_byte(8'h11, 1'b1, t0);
        send_byte(8'h22, 1'b1, t0);
        wait_neg(10);
        total++; if (rx_if.rx_data_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid_held got=%b want=1", rx_if.rx_data_valid); end
        total++; if (rx_if.rx_data !== 8'h11) begin bad++; $display("FAIL ovr_data_held got=%h want=11", rx_if.rx_data); end
        total++; if (ovr_rise - or0 !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d want=1", ovr_rise - or0); end
        total++; if (ovr_cyc - o0 !== 1) begin bad++; $display("FAIL ovr_width got=%0d want=1", ovr_cyc - o0); end
        total++; if (err_cyc - e0 !== 0) begin bad++; $display("FAIL ovr_ferr got=%0d want=0", err_cyc - e0); end
        total++; if (acc_n - a0 !== 0) begin bad++; $display("FAIL ovr_no_accept got=%0d want=0", acc_n - a0); end
        set_ready(1'b1);
        wait_neg(2);
        total++; if (acc_n - a0 !== 1) begin bad++; $display("FAIL ovr_drain_count got=%0d want=1", acc_n - a0); end
        total++; if (acc_data[a0] !== 8'h11) begin bad++; $display("FAIL ovr_drain_data got=%h want=11", acc_data[a0]); end
        total++; if (rx_if.rx_data_valid !== 1'b0) begin bad++; $display("FAIL ovr_valid_drop got=%b want=0", rx_if.rx_data_valid); end
    endtask

    task automatic test_reset_mid_frame;
        int a0, e0, t0;
        logic [7:0] b;
        b  = 8'h5A;
        a0 = acc_n; e0 = err_cyc;
        @(negedge clk);
        rx_pin = 1'b0;
        wait_neg(BIT);
        for (int i = 0; i < 4; i++) begin
            rx_pin = b[i];
            wait_neg(BIT);
        end
        rx_pin = b[4];
        wait_neg(BIT / 2);
        rst_n = 1'b0;
        wait_neg(2);
        total++; if (rx_if.rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h want=00", rx_if.rx_data); end
        total++; if (rx_if.rx_data_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", rx_if.rx_data_valid); end
        total++; if (rx_if.rx_frame_err !== 1'b0 || rx_if.rx_overrun !== 1'b0) begin
            bad++; $display("FAIL rstmid_strobes got=%b%b want=00", rx_if.rx_frame_err, rx_if.rx_overrun);
        end
        rx_pin = 1'b1;
        wait_neg(50);
        rst_n = 1'b1;
        wait_neg(12 * BIT);
        send_byte(8'hC3, 1'b1, t0);
        wait_neg(10);
        total++; if (acc_n - a0 !== 1) begin bad++; $display("FAIL rstmid_count got=%0d want=1", acc_n - a0); end
        total++; if (acc_data[a0] !== 8'hC3) begin bad++; $display("FAIL rstmid_data_after got=%h want=c3", acc_data[a0]); end
        total++; if (err_cyc - e0 !== 0) begin bad++; $display("FAIL rstmid_ferr got=%0d want=0", err_cyc - e0); end
    endtask

    task automatic test_low_at_reset;
        int r0, e0;
        r0 = rise_n; e0 = err_cyc;
        @(negedge clk);
        rx_pin = 1'b0;
        rst_n  = 1'b0;
        wait_neg(10);
        rst_n = 1'b1;
        wait_neg(1000);
        rx_pin = 1'b1;
        wait_neg(5000);
        total++; if (rise_n - r0 !== 0) begin bad++; $display("FAIL lowrst_valid got=%0d want=0", rise_n - r0); end
        total++; if (err_cyc - e0 !== 0) begin bad++; $display("FAIL lowrst_ferr got=%0d want=0", err_cyc - e0); end
    endtask

    task automatic test_exclusive_strobes;
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobes_exclusive got=%0d want=0", both_cnt); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_overrun;
        test_reset_mid_frame;
        test_low_at_reset;
        test_exclusive_strobes;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
